// File: rtl/tsu_queue_regs_if.sv
// Register bus between a host and the time-stamp queue register block.
interface tsu_queue_regs_if #(
  parameter int ADDR_W = 8
);
  logic              wr_in;
  logic              rd_in;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0]       data_in;
  logic [31:0]       data_out;

  modport master (output wr_in, rd_in, addr_in, data_in, input data_out);
  modport slave  (input wr_in, rd_in, addr_in, data_in, output data_out);
endinterface

// File: rtl/tsu_queue_regs.sv
// Per-channel time-stamp queue control/status registers with a pop sequencer
// that pulls the queue head into four readable data words.
module tsu_queue_regs #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  tsu_queue_regs_if.slave       bus,
  output logic [NUM_CH-1:0]     q_rst_out,
  output logic [NUM_CH-1:0]     q_rd_en_out,
  output logic [8*NUM_CH-1:0]   q_ptp_msgid_mask_out,
  input  logic [NUM_CH-1:0]     q_empty_in,
  input  logic [8*NUM_CH-1:0]   q_stat_in,
  input  logic [128*NUM_CH-1:0] q_data_in,
  output logic                  irq_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPT} pop_st_e;

  logic [ADDR_W-1:0] ch_idx;
  logic [2:0]        off;
  logic [NUM_CH-1:0] hit;

  logic [NUM_CH-1:0]        ok_w, ien_w, busy_w;
  logic [NUM_CH-1:0][7:0]   mask_w, ucnt_w, stat_w;
  logic [NUM_CH-1:0][127:0] dat_w;

  logic [31:0] rdata;
  logic [31:0] data_out_q;
  logic        irq_q;

  assign ch_idx = bus.addr_in >> 5;
  assign off    = bus.addr_in[4:2];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pop_st_e     st_q, st_d;
    logic [1:0]  wcnt_q, wcnt_d;
    logic        ok_q, ien_q, qrst_q;
    logic [7:0]  mask_q, ucnt_q, stat_q;
    logic [127:0] dat_q;
    logic        wr_ctrl, wr_cfg, rd_cfg, qrst_req, pop_req, underflow;

    assign hit[c]    = (ch_idx == ADDR_W'(c));
    assign wr_ctrl   = bus.wr_in && hit[c] && (off == 3'd0);
    assign wr_cfg    = bus.wr_in && hit[c] && (off == 3'd1);
    assign rd_cfg    = bus.rd_in && hit[c] && (off == 3'd1);
    // q_rst beats a pop written in the same word
    assign qrst_req  = wr_ctrl && bus.data_in[1];
    assign pop_req   = wr_ctrl && bus.data_in[0] && !bus.data_in[1];
    assign underflow = pop_req && (st_q == IDLE) && q_empty_in[c];

    always_comb begin
      st_d   = st_q;
      wcnt_d = wcnt_q;
      case (st_q)
        IDLE: if (pop_req && !q_empty_in[c]) st_d = REQ;
        REQ: begin
          if (RD_LAT == 1) st_d = CAPT;
          else begin
            st_d   = WAIT;
            wcnt_d = 2'(RD_LAT - 2);
          end
        end
        WAIT: begin
          if (wcnt_q == 2'd0) st_d = CAPT;
          else                wcnt_d = wcnt_q - 2'd1;
        end
        CAPT:    st_d = IDLE;
        default: st_d = IDLE;
      endcase
      if (qrst_req) st_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q   <= IDLE;
        wcnt_q <= '0;
        ok_q   <= 1'b0;
        ien_q  <= 1'b0;
        qrst_q <= 1'b0;
        mask_q <= '0;
        ucnt_q <= '0;
        stat_q <= '0;
        dat_q  <= '0;
      end else begin
        st_q   <= st_d;
        wcnt_q <= wcnt_d;
        qrst_q <= qrst_req;
        stat_q <= q_stat_in[8*c +: 8];
        if (wr_ctrl) ien_q  <= bus.data_in[2];
        if (wr_cfg)  mask_q <= bus.data_in[31:24];

        if (qrst_req) ok_q <= 1'b0;
        else if (st_q == IDLE && st_d == REQ) ok_q <= 1'b0;
        else if (st_q == CAPT) begin
          ok_q  <= 1'b1;
          dat_q <= q_data_in[128*c +: 128];
        end

        // a status read clears the count but keeps an underflow from the same cycle
        if (qrst_req)    ucnt_q <= '0;
        else if (rd_cfg) ucnt_q <= underflow ? 8'd1 : 8'd0;
        else if (underflow && ucnt_q != 8'hFF) ucnt_q <= ucnt_q + 8'd1;
      end
    end

    assign ok_w[c]   = ok_q;
    assign ien_w[c]  = ien_q;
    assign busy_w[c] = (st_q != IDLE);
    assign mask_w[c] = mask_q;
    assign ucnt_w[c] = ucnt_q;
    assign stat_w[c] = stat_q;
    assign dat_w[c]  = dat_q;

    assign q_rst_out[c]               = qrst_q;
    assign q_rd_en_out[c]             = (st_q == REQ);
    assign q_ptp_msgid_mask_out[8*c +: 8] = mask_q;
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit[c]) begin
        case (off)
          3'd0: rdata = {29'd0, ien_w[c], busy_w[c], ok_w[c]};
          3'd1: rdata = {mask_w[c], ucnt_w[c], 8'd0, stat_w[c]};
          3'd4: rdata = dat_w[c][127:96];
          3'd5: rdata = dat_w[c][95:64];
          3'd6: rdata = dat_w[c][63:32];
          3'd7: rdata = dat_w[c][31:0];
          default: rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (bus.rd_in) data_out_q <= rdata;
      irq_q <= |(ok_w & ien_w);
    end
  end

  assign bus.data_out = data_out_q;
  assign irq_out      = irq_q;

endmodule
